// File: rtl/corr_score_engine.sv
// rtl/corr_score_engine.sv - template-correlation scorer over a TPL_W x TPL_H window
// Optional best-score tracking is enabled by defining CORR_BEST_TRACK_EN.
module corr_score_engine #(
  parameter int PIX_W   = 10,
  parameter int TPL_W   = 64,
  parameter int TPL_H   = 48,
  parameter int COORD_W = 13,
  parameter int RD_LAT  = 2,
  parameter int ACC_W   = 32
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iAbort,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_search,
  output logic               oRd_en,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_search,
  output logic [COORD_W-1:0] oY_search,
  output logic               oBusy,
  output logic               oFinished,
`ifdef CORR_BEST_TRACK_EN
  input  logic               iBest_clr,
  output logic [ACC_W-1:0]   oBest_score,
  output logic [COORD_W-1:0] oBest_X,
  output logic [COORD_W-1:0] oBest_Y,
`endif
  output logic [ACC_W-1:0]   oScore
);

  localparam int MIN_ACC_W = $clog2(TPL_W * TPL_H * ((2 ** PIX_W) - 1) + 1);

  generate
    if (ACC_W < MIN_ACC_W) begin : gAccWidthCheck
      $error("corr_score_engine: ACC_W too small for TPL_W*TPL_H*(2^PIX_W-1)");
    end
    if (RD_LAT < 1 || RD_LAT > 7) begin : gLatencyCheck
      $error("corr_score_engine: RD_LAT must be in 1..7");
    end
  endgenerate

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(TPL_H - 1);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [PIX_W:0]     PIX_MAX = {1'b0, {PIX_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state, nextState;
  logic [COORD_W-1:0]   xOrg, yOrg;
  logic [RD_LAT-1:0]    vldPipe;
  logic [ACC_W-1:0]     acc, accNext;
  logic [PIX_W-1:0]     absDiff;
  logic [PIX_W:0]       term;
  logic                 lastAddr, pending, abortRun;

  always_comb begin
    absDiff = (reading_sram >= reading_search) ? (reading_sram - reading_search)
                                               : (reading_search - reading_sram);
    term    = PIX_MAX - {1'b0, absDiff};
    accNext = vldPipe[RD_LAT-1] ? (acc + ACC_W'(term)) : acc;
    // Readings still in flight below the pipe output keep the drain going.
    pending = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) pending = pending | vldPipe[i];
  end

  assign lastAddr  = (oX_search == X_LAST) && (oY_search == Y_LAST);
  assign abortRun  = iAbort && ((state == ISSUE) || (state == DRAIN));
  assign oBusy     = (state != IDLE);
  assign oFinished = (state == DONE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (iStart) nextState = ISSUE;
      ISSUE: if (iAbort) nextState = IDLE;
             else if (lastAddr) nextState = DRAIN;
      DRAIN: if (iAbort) nextState = IDLE;
             else if (!pending) nextState = DONE;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRd_en    <= 1'b0;
      oX_sram   <= '0;
      oY_sram   <= '0;
      oX_search <= '0;
      oY_search <= '0;
      oScore    <= '0;
      xOrg      <= '0;
      yOrg      <= '0;
      vldPipe   <= '0;
      acc       <= '0;
    end else begin
      oRd_en <= (nextState == ISSUE);
      if (abortRun) begin
        vldPipe <= '0;
      end else begin
        vldPipe[0] <= oRd_en;
        for (int i = 1; i < RD_LAT; i++) vldPipe[i] <= vldPipe[i-1];
      end
      if (state == IDLE && iStart) begin
        xOrg      <= iXstart;
        yOrg      <= iYstart;
        acc       <= '0;
        oX_sram   <= iXstart;
        oY_sram   <= iYstart;
        oX_search <= '0;
        oY_search <= '0;
      end else begin
        if (!abortRun) acc <= accNext;
        if (state == ISSUE && nextState == ISSUE) begin
          if (oX_search == X_LAST) begin
            oX_search <= '0;
            oY_search <= oY_search + C_ONE;
            oX_sram   <= xOrg;
            oY_sram   <= yOrg + oY_search + C_ONE;
          end else begin
            oX_search <= oX_search + C_ONE;
            oX_sram   <= xOrg + oX_search + C_ONE;
          end
        end
        // Score is published on entry to DONE so it is valid alongside oFinished.
        if (state == DRAIN && nextState == DONE) oScore <= accNext;
      end
    end
  end

`ifdef CORR_BEST_TRACK_EN
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oBest_score <= '0;
      oBest_X     <= '0;
      oBest_Y     <= '0;
    end else if (iBest_clr) begin
      oBest_score <= '0;
      oBest_X     <= '0;
      oBest_Y     <= '0;
    end else if (state == DONE && oScore > oBest_score) begin
      oBest_score <= oScore;
      oBest_X     <= xOrg;
      oBest_Y     <= yOrg;
    end
  end
`endif

endmodule

// File: tb/tb_corr_score_engine.sv
// tb/tb_corr_score_engine.sv - scoreboard bench for corr_score_engine (CORR_BEST_TRACK_EN optional)
`timescale 1ns/1ps
module tb_corr_score_engine;

  localparam int PIX_W   = 10;
  localparam int TPL_W   = 4;
  localparam int TPL_H   = 2;
  localparam int COORD_W = 13;
  localparam int RD_LAT  = 2;
  localparam int ACC_W   = 32;
  localparam int N       = TPL_W * TPL_H;
  localparam int FIN     = N + RD_LAT + 1;

  logic               iCLK = 1'b0;
  logic               iRST_N = 1'b0;
  logic               iStart = 1'b0;
  logic               iAbort = 1'b0;
  logic [COORD_W-1:0] iXstart = '0;
  logic [COORD_W-1:0] iYstart = '0;
  logic [PIX_W-1:0]   reading_sram, reading_search;
  logic               oRd_en, oBusy, oFinished;
  logic [COORD_W-1:0] oX_sram, oY_sram, oX_search, oY_search;
  logic [ACC_W-1:0]   oScore;
`ifdef CORR_BEST_TRACK_EN
  logic               iBest_clr = 1'b0;
  logic [ACC_W-1:0]   oBest_score;
  logic [COORD_W-1:0] oBest_X, oBest_Y;
`endif

  corr_score_engine #(
    .PIX_W(PIX_W), .TPL_W(TPL_W), .TPL_H(TPL_H),
    .COORD_W(COORD_W), .RD_LAT(RD_LAT), .ACC_W(ACC_W)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iAbort(iAbort),
    .iXstart(iXstart), .iYstart(iYstart),
    .reading_sram(reading_sram), .reading_search(reading_search),
    .oRd_en(oRd_en), .oX_sram(oX_sram), .oY_sram(oY_sram),
    .oX_search(oX_search), .oY_search(oY_search),
    .oBusy(oBusy), .oFinished(oFinished),
`ifdef CORR_BEST_TRACK_EN
    .iBest_clr(iBest_clr), .oBest_score(oBest_score), .oBest_X(oBest_X), .oBest_Y(oBest_Y),
`endif
    .oScore(oScore)
  );

  always #10 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  // Memory model: constant pixels or address-dependent pixels, RD_LAT cycles late.
  bit               constMode = 1'b1;
  logic [PIX_W-1:0] cS = '0, cT = '0;
  logic [PIX_W-1:0] pS [RD_LAT] = '{default: '0};
  logic [PIX_W-1:0] pT [RD_LAT] = '{default: '0};

  function automatic logic [PIX_W-1:0] sramPix(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return PIX_W'((int'(x) * 29 + int'(y) * 53) % 1024);
  endfunction

  function automatic logic [PIX_W-1:0] tplPix(input int tx, input int ty);
    return PIX_W'((tx * 97 + ty * 211 + 5) % 1024);
  endfunction

  function automatic longint expVec(input int x0, input int y0);
    longint s = 0;
    for (int ty = 0; ty < TPL_H; ty++)
      for (int tx = 0; tx < TPL_W; tx++) begin
        int sp, tp, d;
        sp = int'(sramPix(COORD_W'(x0 + tx), COORD_W'(y0 + ty)));
        tp = int'(tplPix(tx, ty));
        d  = (sp > tp) ? sp - tp : tp - sp;
        s  = s + (1023 - d);
      end
    return s;
  endfunction

  always @(posedge iCLK) begin
    if (!oRd_en) begin
      pS[0] <= 10'd77;
      pT[0] <= 10'd77;
    end else if (constMode) begin
      pS[0] <= cS;
      pT[0] <= cT;
    end else begin
      pS[0] <= sramPix(oX_sram, oY_sram);
      pT[0] <= tplPix(int'(oX_search), int'(oY_search));
    end
    for (int i = 1; i < RD_LAT; i++) begin
      pS[i] <= pS[i-1];
      pT[i] <= pT[i-1];
    end
  end
  assign reading_sram   = pS[RD_LAT-1];
  assign reading_search = pT[RD_LAT-1];

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct { longint score; int fcyc; } exp_t;
  exp_t sbQ[$];
  exp_t monE;

  always @(negedge iCLK) begin
    if (oFinished) begin
      if (sbQ.size() == 0) chk("unexpected_finish", oFinished, 0);
      else begin
        monE = sbQ.pop_front();
        chk("score", oScore, monE.score);
        chk("finish_cycle", cyc, monE.fcyc);
      end
    end
  end

  task automatic waitTo(input int c);
    while (cyc < c) @(negedge iCLK);
  endtask

  task automatic doStart(input int x, input int y, input bit push, input longint score, output int c0);
    @(negedge iCLK);
    iXstart = COORD_W'(x);
    iYstart = COORD_W'(y);
    iStart  = 1'b1;
    c0      = cyc;
    if (push) sbQ.push_back('{score, c0 + FIN});
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  task automatic runConst(input int s, input int t, input int x, input int y, input longint score);
    int c0;
    constMode = 1'b1;
    cS = PIX_W'(s);
    cT = PIX_W'(t);
    doStart(x, y, 1'b1, score, c0);
    waitTo(c0 + FIN + 1);
    chk("busy_after_run", oBusy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    longint ev;
    repeat (3) @(negedge iCLK);
    chk("reset_rd_en", oRd_en, 0);
    chk("reset_busy", oBusy, 0);
    chk("reset_finished", oFinished, 0);
    chk("reset_score", oScore, 0);
    chk("reset_x_sram", oX_sram, 0);
    iRST_N = 1'b1;

    // Identical pixels, address sequence and latency.
    constMode = 1'b1; cS = 500; cT = 500;
    doStart(10, 20, 1'b1, 8184, c0);
    for (int k = 1; k <= N; k++) begin
      waitTo(c0 + k);
      chk("rd_en", oRd_en, 1);
      chk("busy", oBusy, 1);
      chk("x_sram", oX_sram, 10 + (k - 1) % TPL_W);
      chk("y_sram", oY_sram, 20 + (k - 1) / TPL_W);
      chk("x_search", oX_search, (k - 1) % TPL_W);
      chk("y_search", oY_search, (k - 1) / TPL_W);
    end
    waitTo(c0 + N + 1);
    chk("rd_en_off", oRd_en, 0);
    chk("x_sram_hold", oX_sram, 13);
    chk("y_sram_hold", oY_sram, 21);
    waitTo(c0 + FIN);
    chk("busy_done", oBusy, 1);
    waitTo(c0 + FIN + 1);
    chk("busy_idle", oBusy, 0);
    chk("score_hold", oScore, 8184);

    runConst(1023, 0, 10, 20, 0);
    runConst(0, 1023, 10, 20, 0);
    runConst(700, 300, 10, 20, 4984);

    // Abort mid-ISSUE.
    cS = 500; cT = 500;
    doStart(10, 20, 1'b0, 0, c0);
    waitTo(c0 + 5);
    iAbort = 1'b1;
    waitTo(c0 + 6);
    iAbort = 1'b0;
    chk("abort_busy", oBusy, 0);
    chk("abort_rd_en", oRd_en, 0);
    waitTo(c0 + FIN + 3);
    chk("abort_score_kept", oScore, 4984);
    runConst(500, 500, 10, 20, 8184);

    // Address-dependent pixels with coordinate wrap; abort during DONE is ignored.
    constMode = 1'b0;
    ev = expVec(8190, 8191);
    doStart(8190, 8191, 1'b1, ev, c0);
    waitTo(c0 + 3);
    chk("x_sram_wrap", oX_sram, 0);
    waitTo(c0 + 5);
    chk("y_sram_wrap", oY_sram, 0);
    waitTo(c0 + FIN);
    iAbort = 1'b1;
    waitTo(c0 + FIN + 1);
    iAbort = 1'b0;
    chk("score_vec_hold", oScore, ev);

    // Reset during DRAIN.
    constMode = 1'b1; cS = 500; cT = 500;
    doStart(10, 20, 1'b0, 0, c0);
    waitTo(c0 + N + 1);
    iRST_N = 1'b0;
    #1;
    chk("rst_busy", oBusy, 0);
    chk("rst_rd_en", oRd_en, 0);
    chk("rst_score", oScore, 0);
    chk("rst_x_sram", oX_sram, 0);
    chk("rst_y_sram", oY_sram, 0);
    chk("rst_y_search", oY_search, 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    runConst(700, 300, 5, 6, 4984);

    // Start held high: back-to-back runs, toggle during ISSUE ignored.
    cS = 500; cT = 500;
    @(negedge iCLK);
    iXstart = 10; iYstart = 20; iStart = 1'b1;
    c0 = cyc;
    sbQ.push_back('{8184, c0 + FIN});
    sbQ.push_back('{8184, c0 + 2 * FIN + 1});
    sbQ.push_back('{8184, c0 + 3 * FIN + 2});
    waitTo(c0 + 3); iStart = 1'b0;
    waitTo(c0 + 4); iStart = 1'b1;
    waitTo(c0 + 2 * (FIN + 1) + 2); iStart = 1'b0;
    waitTo(c0 + 3 * FIN + 3);
    chk("b2b_idle", oBusy, 0);

`ifdef CORR_BEST_TRACK_EN
    @(negedge iCLK); iBest_clr = 1'b1;
    @(negedge iCLK); iBest_clr = 1'b0;
    chk("best_clr_score", oBest_score, 0);
    chk("best_clr_x", oBest_X, 0);
    chk("best_clr_y", oBest_Y, 0);
    runConst(700, 300, 10, 20, 4984);
    chk("best1_score", oBest_score, 4984);
    chk("best1_x", oBest_X, 10);
    runConst(500, 500, 30, 5, 8184);
    runConst(500, 500, 40, 40, 8184);
    chk("best_score", oBest_score, 8184);
    chk("best_x", oBest_X, 30);
    chk("best_y", oBest_Y, 5);
    @(negedge iCLK); iBest_clr = 1'b1;
    @(negedge iCLK); iBest_clr = 1'b0;
    chk("best_clr2_score", oBest_score, 0);
    chk("best_clr2_x", oBest_X, 0);
    chk("best_clr2_y", oBest_Y, 0);
`endif

    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(negedge iCLK);
    chk("scoreboard_empty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
